// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit_if
//  Brief    : Bus bundle between the fetch unit, program RAM and decoder.
//  Revision : 1.0
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              run;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              halted;

    modport master (
        input  run, redirect_valid, redirect_addr, mem_rdata, instr_ready,
        output mem_we, mem_addr, instr_valid, instr, instr_pc, halted
    );

    modport slave (
        output run, redirect_valid, redirect_addr, mem_rdata, instr_ready,
        input  mem_we, mem_addr, instr_valid, instr, instr_pc, halted
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Brief    : Sequential fetch stage with 2-entry output buffer, redirect and
//             run/stop control. Optional halt-opcode detection: HALT_DETECT_EN.
//  Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [ADDR_W-1:0] c_reset_pc = RESET_PC[ADDR_W-1:0];
    localparam logic [CNT_W:0]    c_depth    = BUF_DEPTH[CNT_W:0];
    localparam logic [CNT_W-1:0]  c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef HALT_DETECT_EN
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_STOP  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_inflight;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_word0;
    logic [DATA_W-1:0] r_word1;
    logic [ADDR_W-1:0] r_wpc0;
    logic [ADDR_W-1:0] r_wpc1;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_push_slot0;
    logic [CNT_W:0]    w_used;
`ifdef HALT_DETECT_EN
    logic              w_halt_hit;
    logic              r_halted;
`endif

    always_comb begin
        w_pop        = (r_count != '0) && bus.instr_ready;
        w_push       = r_inflight && !bus.redirect_valid;
        w_push_slot0 = (r_count == '0) || ((r_count == c_cnt_one) && w_pop);
        // Slots still claimed after this edge: buffered + in flight - popped.
        w_used       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight}
                     - {{CNT_W{1'b0}}, w_pop};
`ifdef HALT_DETECT_EN
        w_halt_hit   = w_push && (bus.mem_rdata[DATA_W-1 -: 4] == 4'hF);
`endif

        w_state_next = r_state;
        if (bus.redirect_valid) begin
            w_state_next = bus.run ? ST_FETCH : ST_STOP;
`ifdef HALT_DETECT_EN
        end else if (w_halt_hit || (r_state == ST_HALT)) begin
            w_state_next = ST_HALT;
`endif
        end else if (bus.run) begin
            w_state_next = ST_FETCH;
        end else begin
            w_state_next = ST_STOP;
        end

        // Issue is keyed off the next state so a read goes out on the same
        // edge that samples run, giving the two-cycle start latency.
        w_issue = !bus.redirect_valid && (w_state_next == ST_FETCH)
                && (w_used < c_depth);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= c_reset_pc;
            r_mem_addr <= c_reset_pc;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_word0    <= '0;
            r_word1    <= '0;
            r_wpc0     <= '0;
            r_wpc1     <= '0;
        end else if (bus.redirect_valid) begin
            r_pc       <= bus.redirect_addr;
            r_inflight <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_mem_addr <= r_pc;
                r_pc       <= r_pc + 1'b1;
            end
            r_inflight <= w_issue;
            r_count    <= r_count + {{(CNT_W-1){1'b0}}, w_push}
                                  - {{(CNT_W-1){1'b0}}, w_pop};
            if (w_pop) begin
                r_word0 <= r_word1;
                r_wpc0  <= r_wpc1;
            end
            // The issued PC is still held on mem_addr during capture.
            if (w_push) begin
                if (w_push_slot0) begin
                    r_word0 <= bus.mem_rdata;
                    r_wpc0  <= r_mem_addr;
                end else begin
                    r_word1 <= bus.mem_rdata;
                    r_wpc1  <= r_mem_addr;
                end
            end
        end
    end

`ifdef HALT_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_halt_hit) begin
            r_halted <= 1'b1;
        end
    end
    assign bus.halted = r_halted;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.mem_we      = 1'b0;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr_valid = (r_count != '0);
    assign bus.instr       = r_word0;
    assign bus.instr_pc    = r_wpc0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Brief    : Self-checking bench: stream-order model plus directed scenarios.
//  Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;
    logic clk;
    logic rst_n;
    logic [15:0] ram [256];

    int n_checks;
    int n_errors;

    // Model state: next PC the decoder must see, halt seen, previous cycle info
    logic [7:0]  m_next;
    logic        m_halt;
    logic        p_hold;
    logic        p_redir;
    logic [15:0] p_instr;
    logic [7:0]  p_pc;

    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    instr_fetch_unit #(
        .ADDR_W(8), .DATA_W(16), .RESET_PC(0), .BUF_DEPTH(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rdata = ram[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        if (!rst_n) begin
            chk("rst_valid", bus.instr_valid, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_halted", bus.halted, 0);
            m_next  = 8'd0;
            m_halt  = 1'b0;
            p_hold  = 1'b0;
            p_redir = 1'b0;
            return;
        end
        chk("mem_we", bus.mem_we, 0);
        if (p_redir) begin
            chk("valid_after_redirect", bus.instr_valid, 0);
            chk("halted_after_redirect", bus.halted, 0);
        end
        if (p_hold) begin
            chk("hold_valid", bus.instr_valid, 1);
            chk("hold_instr", bus.instr, p_instr);
            chk("hold_pc", bus.instr_pc, p_pc);
        end
`ifdef HALT_DETECT_EN
        if (m_halt) chk("halted_flag", bus.halted, 1);
`else
        chk("halted_tied", bus.halted, 0);
`endif
        if (bus.redirect_valid) begin
            m_next  = bus.redirect_addr;
            m_halt  = 1'b0;
            p_redir = 1'b1;
            p_hold  = 1'b0;
        end else begin
            p_redir = 1'b0;
            if (bus.instr_valid && bus.instr_ready) begin
                chk("stream_pc", bus.instr_pc, m_next);
                chk("stream_instr", bus.instr, ram[m_next]);
`ifdef HALT_DETECT_EN
                chk("deliver_after_halt", m_halt, 0);
                if (ram[m_next][15:12] == 4'hF) m_halt = 1'b1;
`endif
                m_next = m_next + 8'd1;
            end
            p_hold  = bus.instr_valid && !bus.instr_ready;
            p_instr = bus.instr;
            p_pc    = bus.instr_pc;
        end
    endtask

    // One clock: model compare mid-cycle, then return just after the edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!bus.instr_valid && n < budget) begin
            step();
            n++;
        end
        chk(name, bus.instr_valid, 1);
    endtask

    initial begin
        int exp_pc [4];
        int exp_wd [4];
        logic [7:0] ma;

        n_checks = 0;
        n_errors = 0;
        m_next = 0; m_halt = 0; p_hold = 0; p_redir = 0; p_instr = 0; p_pc = 0;
        for (int k = 0; k < 256; k++) ram[k] = 16'(k * 20);
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = 8'd0;
        repeat (3) step();
        rst_n = 1'b1;

        chk("reset_valid", bus.instr_valid, 0);
        chk("reset_instr", bus.instr, 0);
        chk("reset_instr_pc", bus.instr_pc, 0);
        chk("reset_mem_addr", bus.mem_addr, 0);
        chk("reset_halted", bus.halted, 0);
        repeat (2) step();
        chk("stop_no_issue", bus.mem_addr, 0);
        chk("stop_no_valid", bus.instr_valid, 0);

        // Start latency and streaming
        bus.run = 1'b1;
        bus.instr_ready = 1'b1;
        step();
        chk("latency_c1_valid", bus.instr_valid, 0);
        step();
        chk("latency_c2_valid", bus.instr_valid, 1);
        chk("first_pc", bus.instr_pc, 0);
        chk("first_instr", bus.instr, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("stream_valid", bus.instr_valid, 1);
            chk("stream_lit_pc", bus.instr_pc, k);
            chk("stream_lit_instr", bus.instr, k * 20);
        end

        // PC wrap through redirect
        exp_pc = '{254, 255, 0, 1};
        exp_wd = '{5080, 5100, 0, 20};
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'd254;
        step();
        bus.redirect_valid = 1'b0;
        chk("redirect_clears_valid", bus.instr_valid, 0);
        wait_valid("wrap_timeout", 6);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_pc", bus.instr_pc, exp_pc[k]);
            chk("wrap_instr", bus.instr, exp_wd[k]);
            step();
        end

        // Backpressure
        bus.instr_ready = 1'b0;
        step();
        ma = bus.mem_addr;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_mem_addr_frozen", bus.mem_addr, ma);
            chk("bp_valid", bus.instr_valid, 1);
        end
        bus.instr_ready = 1'b1;
        repeat (4) step();

        // Redirect against a full buffer
        bus.instr_ready = 1'b0;
        repeat (3) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'h40;
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b1;
        wait_valid("redir_timeout", 6);
        chk("redir_pc", bus.instr_pc, 8'h40);
        chk("redir_instr", bus.instr, 1280);

        // Run toggle
        repeat (3) step();
        ma = bus.mem_addr;
        bus.run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stop_mem_addr", bus.mem_addr, ma);
        end
        chk("stop_drained", bus.instr_valid, 0);
        bus.run = 1'b1;
        wait_valid("resume_timeout", 6);
        repeat (3) step();

        // Randomised traffic
        for (int k = 0; k < 800; k++) begin
            bus.instr_ready    = ($urandom_range(0, 3) != 0);
            bus.run            = ($urandom_range(0, 15) != 0);
            bus.redirect_valid = ($urandom_range(0, 39) == 0);
            bus.redirect_addr  = 8'($urandom_range(0, 255));
            step();
        end
        bus.redirect_valid = 1'b0;
        bus.run = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (4) step();

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.instr_valid, 0);
        chk("async_rst_mem_addr", bus.mem_addr, 0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_valid("post_rst_timeout", 6);
        chk("post_rst_pc", bus.instr_pc, 0);
        repeat (3) step();

`ifdef HALT_DETECT_EN
        rst_n = 1'b0;
        ram[3] = 16'hF000;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("halt_flag", bus.halted, 1);
        chk("halt_mem_addr", bus.mem_addr, 3);
        chk("halt_no_valid", bus.instr_valid, 0);
        chk("halt_model_seen", m_halt, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'd0;
        step();
        bus.redirect_valid = 1'b0;
        chk("halt_cleared", bus.halted, 0);
        wait_valid("halt_restart_timeout", 6);
        chk("halt_restart_pc", bus.instr_pc, 0);
        repeat (8) step();
        rst_n = 1'b0;
        ram[3] = 16'd60;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential fetch stage directly upstream of the instruction decoder. Drives read addresses into the 256x16 program/data RAM (we, clk, data_in, addr, data_out) and captures each 16-bit word together with its PC.
- Presents words to the decoder over a valid/ready handshake.
- Handles backpressure with a 2-entry buffer. Supports PC redirect from branch/jump and a run/stop control.

Parameters:
ADDR_W, 8, RAM address width and PC width
DATA_W, 16, instruction word width
RESET_PC, 0, PC loaded at reset
BUF_DEPTH, 2, output buffer entries (fixed at 2; other values unsupported)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
run  input  1  1 = fetching allowed; 0 = no new RAM reads issued
redirect_valid  input  1  one-cycle pulse: load PC from redirect_addr, flush
redirect_addr  input  ADDR_W  new PC on redirect
mem_we  output  1  RAM write enable; held 0 by this block
mem_addr  output  ADDR_W  RAM address
mem_rdata  input  DATA_W  RAM data_out, valid one clk after mem_addr is sampled
instr_valid  output  1  head buffer entry valid
instr_ready  input  1  decoder accepts head entry
instr  output  DATA_W  head instruction word
instr_pc  output  ADDR_W  PC of head instruction
halted  output  1  fetch stopped by halt opcode (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; buffer empty; in-flight flag=0; state=STOP.
  - Outputs: instr_valid=0, instr=0, instr_pc=0, mem_addr=RESET_PC, mem_we=0, halted=0.
- RAM timing: the address registered on edge N yields mem_rdata valid for capture on edge N+1. At most one read is in flight.
- Issue rule, evaluated each cycle:
  - Issue when state=FETCH and (occupancy + inflight) < 2, counting a same-cycle pop as freeing a slot.
  - On issue: mem_addr<=pc, pc<=pc+1 modulo 2^ADDR_W (255 wraps to 0), inflight<=1.
- Capture: if inflight=1 and not squashed, push {mem_rdata, issued_pc} into the buffer.
- Handshake:
  - A transfer occurs when instr_valid & instr_ready. The entry is popped that edge and the next entry, if any, appears the following cycle.
  - instr and instr_pc hold stable while instr_valid=1 and instr_ready=0.
  - No combinational path from instr_ready to instr_valid.
- Throughput: with instr_ready held 1, one instruction per clk after a 2-cycle start latency from run rising to the first instr_valid.
- States:
  - STOP: run=0. Issues nothing. Buffer and in-flight data still drain and capture normally.
  - FETCH: run=1 and not halted.
  - HALT: entered only via the optional feature.
  - Transitions: STOP->FETCH when run=1. FETCH->STOP when run=0. HALT->FETCH only on redirect_valid.
- Redirect (highest priority):
  - Same edge: buffer cleared; any in-flight read squashed, its data discarded next edge; pc<=redirect_addr; halted<=0; state<=FETCH if run=1, else STOP.
  - instr_valid=0 the cycle after redirect. Redirect beats a simultaneous pop and a simultaneous capture.
- Full buffer with instr_ready=0: no issue. The PC does not advance and no word is lost or duplicated.
- Simultaneous push and pop with occupancy 1: occupancy stays 1 and order is preserved.
- Reset mid-operation: everything returns to reset values immediately. In-flight data is discarded.

Optional Feature:
- Macro HALT_DETECT_EN.
- Defined: a captured word with instr[DATA_W-1:DATA_W-4]==4'hF (HALT opcode) is still pushed and delivered. From the capture edge onward no further reads are issued, state<=HALT, halted<=1. A read already in flight at that edge is squashed. Only redirect_valid or reset clears the state.
- Undefined: no opcode inspection, halted tied 0, HALT state absent.

Test Plan:
- Streaming: preload RAM[k]=k*20, reset, run=1, instr_ready=1 -> instr_valid rises 2 clks after run. Sequence instr=0,20,40,... with instr_pc=0,1,2,..., one per clk.
- Wrap: redirect_addr=254 -> instr_pc=254,255,0,1 with instr=5080,5100,0,20 (k*20 truncated to 16 bits).
- Backpressure: instr_ready=0 for 5 clks mid-stream -> occupancy saturates at 2, mem_addr frozen, instr stable. On release, no gaps or duplicates in the PC sequence.
- Redirect with in-flight read and full buffer: redirect_addr=0x40 -> next delivered instr_pc=0x40 (instr=1280). No stale entry appears.
- Run toggle: run=0 for 3 clks -> the buffer drains to empty and no mem_addr change. With run=1 fetch resumes at the next sequential PC.
- HALT_DETECT_EN: RAM[3]=16'hF000 -> PCs 0..3 delivered, halted=1, mem_addr stays 3. Redirect to 0 clears halted and restarts fetch. Async rst_n low mid-stream -> instr_valid=0 immediately.
